// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the memory stage.
// Each 32-bit word request is serialised into four byte transfers, and ME has priority over IF.
module mem_arbiter #(
  parameter int unsigned RamAddrW = 17
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [31:0]         if_addr_i,
  output logic [31:0]         if_data_o,
  output logic                if_busy_o,
  output logic                if_done_o,
  input  logic                me_r_enable_i,
  input  logic                me_w_enable_i,
  input  logic [3:0]          me_w_mask_i,
  input  logic [31:0]         me_w_data_i,
  input  logic [31:0]         me_addr_i,
  output logic [31:0]         me_r_data_o,
  output logic                me_busy_o,
  output logic                me_done_o,
  output logic [RamAddrW-1:0] ram_addr_o,
  output logic                ram_wr_o,
  output logic [7:0]          ram_dout_o,
  input  logic [7:0]          ram_din_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic {OwnIf, OwnMe} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q;
  logic [2:0]            cnt_q, cnt_d;
  logic [RamAddrW-1:2]   base_q;
  logic                  wr_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q;
  logic [31:0]           if_data_q, me_r_data_q;
  logic                  grant_me, grant_if;
  logic                  capture, drive;
  logic [1:0]            cap_idx;
  logic [4:0]            cap_pos, out_pos;

  logic unused_addr;
  assign unused_addr = ^{me_addr_i[31:RamAddrW], me_addr_i[1:0],
                         if_addr_i[31:RamAddrW], if_addr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_me = 1'b0;
    grant_if = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (me_w_enable_i || me_r_enable_i) begin
          grant_me = 1'b1;
          state_d  = StAccess;
        end else if (if_req_i) begin
          grant_if = 1'b1;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        // Reads need a fifth cycle to collect the last byte from the registered RAM.
        if ((wr_q && cnt_q == 3'd3) || cnt_q == 3'd4) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign capture = (state_q == StAccess) && !wr_q && (cnt_q != 3'd0);
  assign cap_idx = cnt_q[1:0] - 2'd1;
  assign cap_pos = {cap_idx, 3'b000};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      owner_q     <= OwnIf;
      base_q      <= '0;
      wr_q        <= 1'b0;
      mask_q      <= 4'd0;
      wdata_q     <= 32'd0;
      if_data_q   <= 32'd0;
      me_r_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_me || grant_if) begin
        owner_q <= grant_me ? OwnMe : OwnIf;
        base_q  <= grant_me ? me_addr_i[RamAddrW-1:2] : if_addr_i[RamAddrW-1:2];
        wr_q    <= grant_me && me_w_enable_i;
        mask_q  <= me_w_mask_i;
        wdata_q <= me_w_data_i;
      end
      if (capture) begin
        if (owner_q == OwnIf) if_data_q[cap_pos +: 8] <= ram_din_i;
        else                  me_r_data_q[cap_pos +: 8] <= ram_din_i;
      end
    end
  end

  assign drive   = (state_q == StAccess) && !cnt_q[2];
  assign out_pos = {cnt_q[1:0], 3'b000};

  always_comb begin
    ram_addr_o = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'd0;
    if (drive) begin
      ram_addr_o = {base_q, cnt_q[1:0]};
      if (wr_q) begin
        ram_wr_o   = mask_q[cnt_q[1:0]];
        ram_dout_o = wdata_q[out_pos +: 8];
      end
    end
  end

  assign if_busy_o   = (state_q != StIdle);
  assign me_busy_o   = (state_q != StIdle);
  assign if_done_o   = (state_q == StDone) && (owner_q == OwnIf);
  assign me_done_o   = (state_q == StDone) && (owner_q == OwnMe);
  assign if_data_o   = if_data_q;
  assign me_r_data_o = me_r_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered byte RAM model.
// Expected values are hand-computed from the preloaded RAM contents.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_busy, if_done;
  logic [31:0] if_addr, if_data;
  logic        me_r_enable, me_w_enable, me_busy, me_done;
  logic [3:0]  me_w_mask;
  logic [31:0] me_w_data, me_addr, me_r_data;
  logic [16:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  mem [0:1023];

  int checks = 0;
  int errors = 0;

  // Per-observation records, indexed by cycle offset from the request cycle T.
  int          first_if_done, first_me_done, if_done_cnt, me_done_cnt;
  logic [31:0] if_data_at, me_data_at;
  int          wr_cnt, busy_first, busy_last, busy_cnt, busy_split;
  logic [31:0] wr_seq, wr_last_addr;
  logic [31:0] addr_log [0:31];
  logic        busy_log [0:31];
  logic        any_log  [0:31];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .if_req_i      (if_req),
    .if_addr_i     (if_addr),
    .if_data_o     (if_data),
    .if_busy_o     (if_busy),
    .if_done_o     (if_done),
    .me_r_enable_i (me_r_enable),
    .me_w_enable_i (me_w_enable),
    .me_w_mask_i   (me_w_mask),
    .me_w_data_i   (me_w_data),
    .me_addr_i     (me_addr),
    .me_r_data_o   (me_r_data),
    .me_busy_o     (me_busy),
    .me_done_o     (me_done),
    .ram_addr_o    (ram_addr),
    .ram_wr_o      (ram_wr),
    .ram_dout_o    (ram_dout),
    .ram_din_i     (ram_din)
  );

  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr] <= pl_data;
    else if (ram_wr) mem[ram_addr[9:0]] <= ram_dout;
    ram_din <= mem[ram_addr[9:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  // Steps n cycles after request cycle T, logging outputs; drops requests once done is seen.
  task automatic observe(input int n, input int if_at, input int rst_at);
    first_if_done = 0; first_me_done = 0; if_done_cnt = 0; me_done_cnt = 0;
    if_data_at = '0; me_data_at = '0; wr_cnt = 0; wr_seq = '0; wr_last_addr = '0;
    busy_first = 0; busy_last = 0; busy_cnt = 0; busy_split = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      addr_log[k] = 32'(ram_addr);
      busy_log[k] = if_busy;
      any_log[k]  = (|if_data) | (|me_r_data) | if_busy | me_busy | if_done | me_done |
                    (|ram_addr) | ram_wr | (|ram_dout);
      if (if_busy !== me_busy) busy_split++;
      if (if_busy) begin
        if (busy_first == 0) busy_first = k;
        busy_last = k;
        busy_cnt++;
      end
      if (ram_wr) begin
        wr_cnt++;
        wr_seq       = {wr_seq[23:0], ram_dout};
        wr_last_addr = 32'(ram_addr);
      end
      if (if_done) begin
        if (first_if_done == 0) begin first_if_done = k; if_data_at = if_data; end
        if_done_cnt++;
        if_req = 1'b0;
      end
      if (me_done) begin
        if (first_me_done == 0) begin first_me_done = k; me_data_at = me_r_data; end
        me_done_cnt++;
        me_r_enable = 1'b0;
        me_w_enable = 1'b0;
      end
      if (k == if_at) if_req = 1'b1;
      if (k == rst_at) begin rst = 1'b1; if_req = 1'b0; end
      if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    if_req = 1'b0; if_addr = '0;
    me_r_enable = 1'b0; me_w_enable = 1'b0; me_w_mask = '0; me_w_data = '0; me_addr = '0;
    step(); step();
    preload(10'h100, 8'h11); preload(10'h101, 8'h22);
    preload(10'h102, 8'h33); preload(10'h103, 8'h44);
    preload(10'h200, 8'ha1); preload(10'h201, 8'hb2);
    preload(10'h202, 8'hc3); preload(10'h203, 8'hd4);
    preload(10'h000, 8'h01); preload(10'h001, 8'h02);
    preload(10'h002, 8'h03); preload(10'h003, 8'h04);

    // Reset state
    check_eq("rst_if_data", if_data, 32'h0);
    check_eq("rst_me_r_data", me_r_data, 32'h0);
    check_eq("rst_busy", {30'd0, if_busy, me_busy}, 32'h0);
    check_eq("rst_done", {30'd0, if_done, me_done}, 32'h0);
    check_eq("rst_ram", {14'd0, ram_wr, ram_addr}, 32'h0);
    check_eq("rst_ram_dout", {24'd0, ram_dout}, 32'h0);
    rst = 1'b0;
    step();

    // IF read of 0x100
    if_req = 1'b1; if_addr = 32'h100;
    observe(8, 0, 0);
    for (int i = 1; i <= 4; i++) check_eq("if_rd_addr", addr_log[i], 32'h100 + 32'(i - 1));
    check_eq("if_rd_wr_cnt", wr_cnt, 0);
    check_eq("if_rd_done_cyc", first_if_done, 6);
    check_eq("if_rd_done_cnt", if_done_cnt, 1);
    check_eq("if_rd_data", if_data_at, 32'h44332211);
    check_eq("if_rd_me_done", me_done_cnt, 0);
    check_eq("if_rd_busy_first", busy_first, 1);
    check_eq("if_rd_busy_last", busy_last, 6);

    // Simultaneous IF and ME reads: ME first
    if_req = 1'b1; if_addr = 32'h0; me_r_enable = 1'b1; me_addr = 32'h203;
    observe(16, 0, 0);
    check_eq("sim_me_done_cyc", first_me_done, 6);
    check_eq("sim_me_data", me_data_at, 32'hd4c3b2a1);
    check_eq("sim_idle_t7", {31'd0, busy_log[7]}, 32'h0);
    check_eq("sim_busy_t8", {31'd0, busy_log[8]}, 32'h1);
    check_eq("sim_if_done_cyc", first_if_done, 13);
    check_eq("sim_if_data", if_data_at, 32'h04030201);

    // SB-style write of one lane
    me_w_enable = 1'b1; me_addr = 32'h102; me_w_mask = 4'b0100; me_w_data = 32'hABABABAB;
    observe(8, 0, 0);
    check_eq("sb_wr_cnt", wr_cnt, 1);
    check_eq("sb_wr_addr", wr_last_addr, 32'h102);
    check_eq("sb_wr_data", wr_seq, 32'h000000ab);
    check_eq("sb_done_cyc", first_me_done, 5);
    check_eq("sb_busy_last", busy_last, 5);
    check_eq("sb_rdata_kept", me_r_data, 32'hd4c3b2a1);
    me_r_enable = 1'b1; me_addr = 32'h100;
    observe(8, 0, 0);
    check_eq("sb_readback", me_data_at, 32'h44AB2211);

    // SW write with an IF request raised during ACCESS
    me_w_enable = 1'b1; me_addr = 32'h104; me_w_mask = 4'b1111; me_w_data = 32'hDEADBEEF;
    if_addr = 32'h104;
    observe(14, 2, 0);
    check_eq("sw_wr_cnt", wr_cnt, 4);
    check_eq("sw_wr_order", wr_seq, 32'hEFBEADDE);
    check_eq("sw_wr_last_addr", wr_last_addr, 32'h107);
    check_eq("sw_done_cyc", first_me_done, 5);
    check_eq("sw_idle_t6", {31'd0, busy_log[6]}, 32'h0);
    check_eq("sw_if_done_cyc", first_if_done, 12);
    check_eq("sw_if_data", if_data_at, 32'hDEADBEEF);

    // Reset in cycle T+3 of an IF read
    if_req = 1'b1; if_addr = 32'h100;
    observe(10, 0, 3);
    check_eq("rstmid_busy_t3", {31'd0, busy_log[3]}, 32'h1);
    check_eq("rstmid_outs_t4", {31'd0, any_log[4]}, 32'h0);
    check_eq("rstmid_no_done", if_done_cnt, 0);
    check_eq("rstmid_if_data", if_data, 32'h0);

    // Mask 0000 write
    me_w_enable = 1'b1; me_addr = 32'h10; me_w_mask = 4'b0000; me_w_data = 32'h12345678;
    observe(8, 0, 0);
    check_eq("m0_wr_cnt", wr_cnt, 0);
    check_eq("m0_done_cyc", first_me_done, 5);
    check_eq("m0_busy_first", busy_first, 1);
    check_eq("m0_busy_last", busy_last, 5);
    check_eq("m0_busy_cnt", busy_cnt, 5);
    check_eq("busy_equal", busy_split, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
